// File: rtl/axi64_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : axi64_slave_mem_if
// Brief    : AXI4 64-bit read/write channel bundle with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface axi64_slave_mem_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [ID_WIDTH-1:0]   arid;

    logic                  rvalid;
    logic                  rready;
    logic [63:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [ID_WIDTH-1:0]   awid;

    logic                  wvalid;
    logic                  wready;
    logic [63:0]           wdata;
    logic [7:0]            wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [ID_WIDTH-1:0]   bid;

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );
endinterface
`default_nettype wire

// File: rtl/axi64_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi64_slave_mem
// Brief    : AXI4 64-bit slave on on-chip RAM; one read and one write burst
//            in flight, independent channels, full ID reflection.
// Revision : 1.0 - initial release
// ============================================================================
module axi64_slave_mem #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 65536
) (
    input  logic             clk,
    input  logic             rst,
    axi64_slave_mem_if.slave s_axi
);

    localparam int c_WORDS  = MEM_BYTES / 8;
    localparam int c_ABITS  = $clog2(MEM_BYTES);
    localparam int c_IDX_W  = (c_ABITS > 3) ? (c_ABITS - 3) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_MASK    = c_IDX_W'(c_WORDS - 1);
    localparam logic [1:0]         c_BURST_FIXED = 2'b00;
    localparam logic [1:0]         c_BURST_WRAP  = 2'b10;
    localparam logic [1:0]         c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]         c_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    // Upper address bits and addr[2:0] drop out here: accesses alias modulo MEM_BYTES.
    function automatic logic [c_IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return c_IDX_W'(addr >> 3) & c_IDX_MASK;
    endfunction

    function automatic logic [c_IDX_W-1:0] next_idx(input logic [c_IDX_W-1:0] idx,
                                                    input logic [1:0]         burst);
        if (burst == c_BURST_FIXED) begin
            return idx;
        end
        return (idx + c_IDX_W'(1)) & c_IDX_MASK;
    endfunction

    function automatic logic [1:0] resp_code(input logic [2:0] size, input logic [1:0] burst);
        return ((size != 3'd3) || (burst == c_BURST_WRAP)) ? c_RESP_SLVERR : c_RESP_OKAY;
    endfunction

    logic [63:0] mem [0:c_WORDS-1];

    // ------------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------------
    rstate_t              rstate_q;
    logic                 arready_q;
    logic                 rvalid_q;
    logic [63:0]          rdata_q;
    logic [1:0]           rresp_q;
    logic                 rlast_q;
    logic [ID_WIDTH-1:0]  rid_q;
    logic [c_IDX_W-1:0]   ridx_q;
    logic [7:0]           rlen_q;
    logic [7:0]           rcnt_q;
    logic [1:0]           rburst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= c_RESP_OKAY;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rburst_q  <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (s_axi.arvalid && arready_q) begin
                        ridx_q    <= word_idx(s_axi.araddr);
                        rlen_q    <= s_axi.arlen;
                        rburst_q  <= s_axi.arburst;
                        rid_q     <= s_axi.arid;
                        rresp_q   <= resp_code(s_axi.arsize, s_axi.arburst);
                        rcnt_q    <= '0;
                        arready_q <= 1'b0;
                        rstate_q  <= R_FETCH;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_FETCH: begin
                    rdata_q  <= mem[ridx_q];
                    rlast_q  <= (rcnt_q == rlen_q);
                    rvalid_q <= 1'b1;
                    rstate_q <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            rlast_q  <= 1'b0;
                            rstate_q <= R_IDLE;
                        end else begin
                            ridx_q   <= next_idx(ridx_q, rburst_q);
                            rcnt_q   <= rcnt_q + 8'd1;
                            rstate_q <= R_FETCH;
                        end
                    end
                end
                default: begin
                    rstate_q  <= R_IDLE;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------------
    wstate_t              wstate_q;
    logic                 awready_q;
    logic                 wready_q;
    logic                 bvalid_q;
    logic [1:0]           bresp_q;
    logic [ID_WIDTH-1:0]  bid_q;
    logic [c_IDX_W-1:0]   widx_q;
    logic [7:0]           wlen_q;
    logic [7:0]           wcnt_q;
    logic [1:0]           wburst_q;
    logic                 wr_en_d;

    assign wr_en_d = !rst && (wstate_q == W_DATA) && s_axi.wvalid && wready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= c_RESP_OKAY;
            bid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wburst_q  <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (s_axi.awvalid && awready_q) begin
                        widx_q    <= word_idx(s_axi.awaddr);
                        wlen_q    <= s_axi.awlen;
                        wburst_q  <= s_axi.awburst;
                        bid_q     <= s_axi.awid;
                        bresp_q   <= resp_code(s_axi.awsize, s_axi.awburst);
                        wcnt_q    <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (s_axi.wvalid && wready_q) begin
                        // A misplaced wlast only flags the response; len still ends the burst.
                        if (s_axi.wlast != (wcnt_q == wlen_q)) begin
                            bresp_q <= c_RESP_SLVERR;
                        end
                        widx_q <= next_idx(widx_q, wburst_q);
                        wcnt_q <= wcnt_q + 8'd1;
                        if (wcnt_q == wlen_q) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q <= 1'b0;
                        wstate_q <= W_IDLE;
                    end
                end
                default: begin
                    wstate_q  <= W_IDLE;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // RAM is not reset; same-cycle fetch of a word being written sees the old value.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[widx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                end
            end
        end
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.bid     = bid_q;

endmodule
`default_nettype wire
